// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port over a local word array
// with a fixed number of wait states between request accept and response.
module dmem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   localparam logic [32:0] BASE33   = {1'b0, BASE_ADDR};
   localparam logic [32:0] DEPTH33  = 33'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic              acc_c;
   logic              acc_write_c;
   logic [31:0]       acc_addr_c;
   logic [31:0]       acc_wdata_c;
   logic [3:0]        acc_be_c;
   logic [32:0]       off_c;
   logic              err_c;
   logic [IDX_W-1:0]  idx_c;
   logic [31:0]       bemask_c;
   logic              mem_we_c;
   logic [31:0]       mem_rd [DEPTH];

   // With zero wait states the access happens on the accept edge, straight from the request pins.
   always_comb begin
      acc_write_c = write_q;
      acc_addr_c  = addr_q;
      acc_wdata_c = wdata_q;
      acc_be_c    = be_q;
      if (state_q == S_IDLE) begin
         acc_write_c = req_write_i;
         acc_addr_c  = req_addr_i;
         acc_wdata_c = req_wdata_i;
         acc_be_c    = req_be_i;
      end
      off_c    = {1'b0, acc_addr_c} - BASE33;
      err_c    = (acc_addr_c[1:0] != 2'b00) | ({1'b0, acc_addr_c} < BASE33)
               | ((off_c >> 2) >= DEPTH33);
      idx_c    = off_c[IDX_W+1:2];
      bemask_c = {{8{acc_be_c[3]}}, {8{acc_be_c[2]}}, {8{acc_be_c[1]}}, {8{acc_be_c[0]}}};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      acc_c       = 1'b0;
      mem_we_c    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               be_d    = req_be_i;
               if (WAIT_CYCLES == 0) begin
                  acc_c   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               acc_c   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d     = S_IDLE;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (acc_c) begin
         rsp_err_d   = err_c;
         rsp_rdata_d = (err_c || acc_write_c) ? 32'h0 : mem_rd[idx_c];
         mem_we_c    = !err_c && acc_write_c;
      end
      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         be_q        <= 4'h0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // One register per word so each has its own byte-masked update and reset.
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      logic [31:0] word_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            word_q <= 32'h0;
         end else if (mem_we_c && (idx_c == IDX_W'(g))) begin
            word_q <= (word_q & ~bemask_c) | (acc_wdata_c & bemask_c);
         end
      end
      assign mem_rd[g] = word_q;
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of load/store transactions
// plus hand sequences for response back-pressure and reset during a wait.
module tb_dmem_responder;

   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_be_i    (req_be),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one request, measure accept-to-response latency, check payload, then handshake.
   task automatic do_txn(input string tag, input vec_t v);
      int edges;
      @(negedge clk);
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = v.write;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_be    = v.be;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'hA5A5_A5A5;
      req_be    = 4'hF;
      while (!rsp_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check({tag, " latency"}, 32'(edges), 32'(LAT));
      check({tag, " rdata"}, rsp_rdata, v.exp_rdata);
      check({tag, " err"}, 32'(rsp_err), 32'(v.exp_err));
      check({tag, " ready_in_resp"}, 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, " valid_cleared"}, {rsp_valid, rsp_err, req_ready, rsp_rdata[28:0]},
            {1'b0, 1'b0, 1'b1, 29'h0});
   endtask

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF,  4'hF, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'h11223344,  4'hF, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b1, 32'h0000_0020, 32'hAABBCCDD,  4'h5, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB33DD, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_0400, 32'hFFFFFFFF,  4'hF, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_03FC, 32'h12345678,  4'h0, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
      vecs[13] = '{1'b1, 32'h0000_03FC, 32'hCAFEF00D,  4'h8, 32'h0000_0000, 1'b0};
      vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0000_0000, 1'b1};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         do_txn($sformatf("vec%0d", i), vecs[i]);
      end
      do_txn("ofs3FC_msb", '{1'b0, 32'h0000_03FC, 32'h0, 4'h0, 32'hCA000000, 1'b0});

      // Back-pressure: hold rsp_ready low with a second request already waiting.
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0010;
      @(posedge clk);
      begin
         int guard = 0;
         @(negedge clk);
         while (!rsp_valid && guard < 20) begin
            @(posedge clk);
            guard++;
            @(negedge clk);
         end
      end
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d", c), {rsp_valid, rsp_err, req_ready, rsp_rdata[28:0]},
               {1'b1, 1'b0, 1'b0, 29'h1EADBEEF});
         check($sformatf("stall%0d rdata", c), rsp_rdata, 32'hDEADBEEF);
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("stall release valid", 32'(rsp_valid), 32'd0);
      check("stall release ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("held req accepted", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("held req valid", 32'(rsp_valid), 32'd1);
      check("held req rdata", rsp_rdata, 32'hDEADBEEF);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset while a store is waiting: outputs drop at once and the store is lost.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0040;
      req_wdata = 32'h55555555;
      req_be    = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("pre-reset in wait", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst async req_ready", 32'(req_ready), 32'd1);
      check("rst async rsp", {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'h0);
      repeat (4) begin
         @(posedge clk);
         #1;
         check("rst hold rsp_valid", 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("after rst rsp_valid", 32'(rsp_valid), 32'd0);
      do_txn("lost store", '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 1'b0});
      do_txn("array cleared", '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
